countdown_timer: RTL

- Four-digit BCD MM:SS down-counter with load, start, pause and expiry signalling.
- Counterpart to the up-counting digit timer: it consumes the same 1-cycle per-second strobe on `enable` and borrows between digits instead of carrying.
- Feeds the 7-segment display mux through its digit outputs.
- Feeds game/control logic through `done` and `expired`.

---
 rtl/countdown_timer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS down-counter with load, start/pause control and
// expiry signalling; counts down one second per enable strobe while running.
module countdown_timer #(
  parameter int unsigned MIN_TENS_MAX = 5,
  parameter int unsigned SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_ones,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] MT_MAX   = DW'(MIN_TENS_MAX);
  localparam logic [DW-1:0] ST_MAX   = DW'(SEC_TENS_MAX);
  localparam logic [DW-1:0] ONES_MAX = DW'(9);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t state;

  logic [DW-1:0] dec_mt, dec_mo, dec_st, dec_so;
  logic [DW-1:0] clamp_mt, clamp_mo, clamp_st, clamp_so;
  logic          borrow_so, borrow_st, borrow_mo;
  logic          at_zero, at_one;

  // Borrow chain for one-second decrement, plus clamped load digits
  always_comb begin
    borrow_so = (sec_ones == '0);
    dec_so    = borrow_so ? ONES_MAX : sec_ones - DW'(1);

    borrow_st = borrow_so && (sec_tens == '0);
    dec_st    = sec_tens;
    if (borrow_so) dec_st = (sec_tens == '0) ? ST_MAX : sec_tens - DW'(1);

    borrow_mo = borrow_st && (min_ones == '0);
    dec_mo    = min_ones;
    if (borrow_st) dec_mo = (min_ones == '0) ? ONES_MAX : min_ones - DW'(1);

    dec_mt = min_tens;
    if (borrow_mo) dec_mt = min_tens - DW'(1);

    clamp_mt = (load_min_tens > MT_MAX)   ? MT_MAX   : load_min_tens;
    clamp_mo = (load_min_ones > ONES_MAX) ? ONES_MAX : load_min_ones;
    clamp_st = (load_sec_tens > ST_MAX)   ? ST_MAX   : load_sec_tens;
    clamp_so = (load_sec_ones > ONES_MAX) ? ONES_MAX : load_sec_ones;

    at_zero = (min_tens == '0) && (min_ones == '0) &&
              (sec_tens == '0) && (sec_ones == '0);
    at_one  = (min_tens == '0) && (min_ones == '0) &&
              (sec_tens == '0) && (sec_ones == DW'(1));
  end

  // Control FSM with registered digits and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      min_tens <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      running  <= 1'b0;
      expired  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, PAUSED, EXPIRED: begin
          if (load) begin
            min_tens <= clamp_mt;
            min_ones <= clamp_mo;
            sec_tens <= clamp_st;
            sec_ones <= clamp_so;
            state    <= IDLE;
            running  <= 1'b0;
            expired  <= 1'b0;
          end else if (start && !at_zero && state != EXPIRED) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state   <= PAUSED;
            running <= 1'b0;
          end else if (enable && !at_zero) begin
            min_tens <= dec_mt;
            min_ones <= dec_mo;
            sec_tens <= dec_st;
            sec_ones <= dec_so;
            if (at_one) begin
              state   <= EXPIRED;
              running <= 1'b0;
              expired <= 1'b1;
              done    <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule
